// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream
//  Description : Read-side drain for a synchronous FIFO with fixed read
//                latency. Issues FIFO reads against a credit count covering
//                buffered plus in-flight words, and presents the words as a
//                valid/ready stream at up to one word per clock. The FIFO
//                read strobe never depends on the stream ready input.
//  Ports       : clk_i        rising-edge clock
//                rst_ni       asynchronous active-low reset
//                empty_i      FIFO empty flag
//                rd_en_o      FIFO read strobe
//                rd_data_i    FIFO read data, valid RD_LAT clocks after rd_en_o
//                out_valid_o  stream data valid
//                out_ready_i  stream consumer ready
//                out_data_o   stream data (zero while nothing is buffered)
//                out_cnt_o    count of accepted stream words (wraps)
//                idle_o       nothing buffered and no reads in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             empty_i,
    output logic             rd_en_o,
    input  logic [WIDTH-1:0] rd_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0] out_cnt_o,
    output logic             idle_o
);

    // Two spare entries beyond the read latency let a read be issued every
    // clock while the consumer keeps up.
    localparam int BUF   = RD_LAT + 2;
    localparam int PTR_W = $clog2(BUF);
    localparam int OCC_W = $clog2(BUF + 1) + 1;

    generate
        if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_rd_lat
            $fatal(1, "fifo_rd_stream: RD_LAT must be 1 or 2");
        end
    endgenerate

    logic [WIDTH-1:0]  mem_q [BUF];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  cnt_q, cnt_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;

    logic              capture;
    logic              pop;
    logic [OCC_W-1:0]  inflight;
    logic [OCC_W-1:0]  occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OCC_W'(pipe_q[i]);
        end
    end

    // Credit covers words already buffered plus words still in the FIFO read
    // pipeline, so every issued read is guaranteed a free slot on arrival.
    // Gating with rst_ni keeps the strobe low for the whole reset period.
    assign occ         = cnt_q + inflight;
    assign rd_en_o     = rst_ni & ~empty_i & (occ < OCC_W'(BUF));

    assign capture     = pipe_q[RD_LAT-1];
    assign out_valid_o = (cnt_q != '0);
    assign pop         = out_valid_o & out_ready_i;
    assign out_data_o  = out_valid_o ? mem_q[head_q] : '0;
    assign out_cnt_o   = out_cnt_q;
    assign idle_o      = (cnt_q == '0) & (inflight == '0);

    always_comb begin
        // Shift the read strobe into stage 0; the oldest stage falls off.
        pipe_d    = RD_LAT'({pipe_q, rd_en_o});
        head_d    = pop ? ptr_inc(head_q) : head_q;
        tail_d    = capture ? ptr_inc(tail_q) : tail_q;
        out_cnt_d = pop ? out_cnt_q + CNT_W'(1) : out_cnt_q;
        cnt_d     = cnt_q;
        unique case ({capture, pop})
            2'b10:   cnt_d = cnt_q + OCC_W'(1);
            2'b01:   cnt_d = cnt_q - OCC_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            pipe_q    <= '0;
            out_cnt_q <= '0;
            for (int i = 0; i < BUF; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            pipe_q    <= pipe_d;
            out_cnt_q <= out_cnt_d;
            if (capture) begin
                mem_q[tail_q] <= rd_data_i;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(capture && (cnt_q == OCC_W'(BUF))));
    a_no_read_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rd_en_o && empty_i));
`endif

endmodule
`default_nettype wire
